// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with optional parity, runtime bit divider and a
// single-entry ready/ack output register.
`default_nettype none

module uart_rx (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        ack_i,
  input  logic        parity_bit_i,
  input  logic        parity_even_i,
  input  logic        serial_i,
  input  logic [15:0] clock_divider_i,
  output logic [7:0]  data_o,
  output logic        ready_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] div_q;
  logic [15:0] cnt;
  logic        par_en;
  logic        par_even;
  logic        bad;
  logic        wait_high;
  logic        ack_q;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;

  logic [15:0] div_eff;
  logic        ack_edge;
  logic        tick;

  assign div_eff  = (clock_divider_i < 16'd2) ? 16'd2 : clock_divider_i;
  assign ack_edge = ack_i & ~ack_q;
  assign tick     = (cnt == 16'd0);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= S_IDLE;
      div_q     <= 16'd0;
      cnt       <= 16'd0;
      par_en    <= 1'b0;
      par_even  <= 1'b0;
      bad       <= 1'b0;
      wait_high <= 1'b0;
      ack_q     <= 1'b0;
      shift     <= 8'h00;
      bit_idx   <= 3'd0;
      data_o    <= 8'h00;
      ready_o   <= 1'b0;
    end else begin
      ack_q <= ack_i;
      if (ack_edge)
        ready_o <= 1'b0;

      // Bit-period counter: zero marks a sample point, then reloads a full bit.
      if (state != S_IDLE) begin
        if (tick)
          cnt <= div_q - 16'd1;
        else
          cnt <= cnt - 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (wait_high) begin
            if (serial_i)
              wait_high <= 1'b0;
          end else if (!serial_i) begin
            div_q    <= div_eff;
            par_en   <= parity_bit_i;
            par_even <= parity_even_i;
            cnt      <= (div_eff >> 1) - 16'd1;
            bad      <= 1'b0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            if (serial_i) begin
              state <= S_IDLE;
            end else begin
              bit_idx <= 3'd0;
              state   <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            shift   <= {serial_i, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= par_en ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: begin
          if (tick) begin
            bad   <= (^shift) ^ serial_i ^ ~par_even;
            state <= S_STOP;
          end
        end

        S_STOP: begin
          if (tick) begin
            state <= S_IDLE;
            if (!serial_i) begin
              wait_high <= 1'b1;
            end else if (!bad && (!ready_o || ack_edge)) begin
              // Overrides the ack clear above: a completing frame wins the cycle.
              data_o  <= shift;
              ready_o <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
`default_nettype none

module tb_uart_rx;

  logic        clk;
  logic        reset_i;
  logic        ack_i;
  logic        parity_bit_i;
  logic        parity_even_i;
  logic        serial_i;
  logic [15:0] clock_divider_i;
  logic [7:0]  data_o;
  logic        ready_o;

  int vectors;
  int miscompares;

  uart_rx dut (
    .clock_i         (clk),
    .reset_i         (reset_i),
    .ack_i           (ack_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .serial_i        (serial_i),
    .clock_divider_i (clock_divider_i),
    .data_o          (data_o),
    .ready_o         (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame, each bit held d cycles from a falling edge.
  task automatic send_frame(input logic [7:0] data, input int d, input logic par_en,
                            input logic par_val, input logic stop_val,
                            input logic [15:0] div_after);
    @(negedge clk);
    serial_i = 1'b0;
    @(negedge clk);
    clock_divider_i = div_after;
    repeat (d - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_i = data[i];
      repeat (d) @(negedge clk);
    end
    if (par_en) begin
      serial_i = par_val;
      repeat (d) @(negedge clk);
    end
    serial_i = stop_val;
    repeat (d) @(negedge clk);
  endtask

  task automatic ack_pulse(input string tag);
    @(negedge clk);
    ack_i = 1'b1;
    #1;
    check({tag, "_same_cycle"}, {15'd0, ready_o}, 16'd1);
    @(posedge clk);
    #1;
    check({tag, "_cleared"}, {15'd0, ready_o}, 16'd0);
    @(negedge clk);
    ack_i = 1'b0;
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset_i         = 1'b1;
    ack_i           = 1'b0;
    parity_bit_i    = 1'b0;
    parity_even_i   = 1'b1;
    serial_i        = 1'b1;
    clock_divider_i = 16'd2;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {15'd0, ready_o}, 16'd0);
    check("reset_data", {8'd0, data_o}, 16'h0000);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (3) @(negedge clk);

    // Basic receive, D=2: stop sampled one edge into the stop bit.
    send_frame(8'h55, 2, 1'b0, 1'b0, 1'b1, 16'd2);
    check("basic_ready", {15'd0, ready_o}, 16'd1);
    check("basic_data", {8'd0, data_o}, 16'h0055);

    // Ack held high clears once.
    @(negedge clk);
    ack_i = 1'b1;
    #1;
    check("ackhold_same_cycle", {15'd0, ready_o}, 16'd1);
    @(posedge clk);
    #1;
    check("ackhold_cleared", {15'd0, ready_o}, 16'd0);

    send_frame(8'hAA, 2, 1'b0, 1'b0, 1'b1, 16'd2);
    check("ackhold_aa_ready", {15'd0, ready_o}, 16'd1);
    check("ackhold_aa_data", {8'd0, data_o}, 16'h00AA);

    send_frame(8'hCC, 2, 1'b0, 1'b0, 1'b1, 16'd2);
    check("drop_cc_ready", {15'd0, ready_o}, 16'd1);
    check("drop_cc_data", {8'd0, data_o}, 16'h00AA);

    @(negedge clk);
    ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("ack_fall_ready", {15'd0, ready_o}, 16'd1);

    ack_pulse("pulse1");

    // Parity: 0x07 has three ones.
    parity_bit_i  = 1'b1;
    parity_even_i = 1'b1;
    send_frame(8'h07, 2, 1'b1, 1'b1, 1'b1, 16'd2);
    check("par_even_ok_ready", {15'd0, ready_o}, 16'd1);
    check("par_even_ok_data", {8'd0, data_o}, 16'h0007);
    ack_pulse("pulse2");

    send_frame(8'h07, 2, 1'b1, 1'b0, 1'b1, 16'd2);
    check("par_even_bad_ready", {15'd0, ready_o}, 16'd0);

    parity_even_i = 1'b0;
    send_frame(8'h07, 2, 1'b1, 1'b0, 1'b1, 16'd2);
    check("par_odd_ok_ready", {15'd0, ready_o}, 16'd1);
    ack_pulse("pulse3");

    // Framing error followed by a held break.
    parity_bit_i  = 1'b0;
    parity_even_i = 1'b1;
    send_frame(8'h12, 2, 1'b0, 1'b0, 1'b0, 16'd2);
    repeat (30) @(negedge clk);
    check("framing_ready", {15'd0, ready_o}, 16'd0);
    check("framing_data", {8'd0, data_o}, 16'h0007);
    serial_i = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h34, 2, 1'b0, 1'b0, 1'b1, 16'd2);
    check("after_break_ready", {15'd0, ready_o}, 16'd1);
    check("after_break_data", {8'd0, data_o}, 16'h0034);
    ack_pulse("pulse4");

    // One-cycle glitch with D=8.
    clock_divider_i = 16'd8;
    @(negedge clk);
    serial_i = 1'b0;
    @(negedge clk);
    serial_i = 1'b1;
    repeat (90) @(negedge clk);
    check("glitch_ready", {15'd0, ready_o}, 16'd0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16'd8);
    check("d8_ready", {15'd0, ready_o}, 16'd1);
    check("d8_data", {8'd0, data_o}, 16'h005A);
    ack_pulse("pulse5");

    // D=16 with the divider input changed right after the start is detected.
    clock_divider_i = 16'd16;
    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 16'd3);
    check("d16_ready", {15'd0, ready_o}, 16'd1);
    check("d16_data", {8'd0, data_o}, 16'h00A5);
    ack_pulse("pulse6");

    // Divider 0 behaves as 2.
    clock_divider_i = 16'd0;
    send_frame(8'h81, 2, 1'b0, 1'b0, 1'b1, 16'd0);
    check("div0_ready", {15'd0, ready_o}, 16'd1);
    check("div0_data", {8'd0, data_o}, 16'h0081);

    // Asynchronous reset mid-frame while a byte is pending.
    clock_divider_i = 16'd2;
    @(negedge clk);
    serial_i = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    reset_i = 1'b1;
    #1;
    check("midreset_ready", {15'd0, ready_o}, 16'd0);
    check("midreset_data", {8'd0, data_o}, 16'h0000);
    @(negedge clk);
    serial_i = 1'b1;
    reset_i  = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h3C, 2, 1'b0, 1'b0, 1'b1, 16'd2);
    check("postreset_ready", {15'd0, ready_o}, 16'd1);
    check("postreset_data", {8'd0, data_o}, 16'h003C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
